// File: rtl/vram_write_sched.sv
// Video RAM write-port scheduler: bulk image ROM -> RAM copy sharing
// the single write port with a prioritised host channel.
module vram_write_sched #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 18,
    parameter int DEPTH      = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_ad,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_gnt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_data
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     SMAX = SW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ad_q, ad_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic loader_win;
    logic ld_wr;

    // Abort vetoes the loader write but does not hand the slot to the host.
    assign loader_win = (state_q == S_WRITE)
                      && (!host_req || starve_q == SMAX);
    assign ld_wr      = loader_win && !abort;
    assign host_gnt   = rst && host_req && !loader_win;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        starve_d = '0;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (ld_wr) begin
                    if (addr_q == LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + 1'b1;
                    end
                end else if (host_gnt && starve_q != SMAX) begin
                    starve_d = starve_q + 1'b1;
                end else begin
                    starve_d = starve_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            addr_d   = '0;
            starve_d = '0;
            done_d   = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        we_d   = 1'b0;
        ad_d   = ad_q;
        data_d = data_q;
        if (ld_wr) begin
            we_d   = 1'b1;
            ad_d   = addr_q;
            data_d = rom_data;
        end else if (host_gnt) begin
            we_d   = 1'b1;
            ad_d   = host_ad;
            data_d = host_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            starve_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            ad_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            ad_q     <= ad_d;
            data_q   <= data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_ad   = addr_q;
    assign ram_we   = we_q;
    assign ram_ad   = ad_q;
    assign ram_data = data_q;

endmodule

// File: tb/tb_vram_write_sched.sv
// Scoreboard bench for vram_write_sched: DEPTH=8, STARVE_MAX=4,
// ROM word = address ^ 18'h155.
module tb_vram_write_sched;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int DEPTH = 8;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_ad;
    logic [DW-1:0] rom_data = '0;
    logic          host_req;
    logic [AW-1:0] host_ad;
    logic [DW-1:0] host_data;
    logic          host_gnt;
    logic          ram_we;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_data;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] expq[$];

    vram_write_sched #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH(DEPTH),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .rom_ad(rom_ad),
        .rom_data(rom_data),
        .host_req(host_req),
        .host_ad(host_ad),
        .host_data(host_data),
        .host_gnt(host_gnt),
        .ram_we(ram_we),
        .ram_ad(ram_ad),
        .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one cycle read latency.
    always @(posedge clk) rom_data <= DW'(rom_ad) ^ 18'h155;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW+DW-1:0] lw(input int k);
        return {AW'(k), DW'(k) ^ 18'h155};
    endfunction

    function automatic logic [AW+DW-1:0] hw(input int j);
        return {10'h200 + AW'(j), 18'h30000 ^ DW'(j)};
    endfunction

    // Monitor: every RAM write must match the head of the queue.
    always @(negedge clk) begin
        if (rst && ram_we) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write ad %0h data %0h t=%0t",
                         ram_ad, ram_data, $time);
            end else begin
                chk("ram_write", {ram_ad, ram_data}, 32'(expq.pop_front()));
            end
        end
    end

    task automatic run_load(input int glitch);
        for (int k = 0; k < DEPTH; k++) expq.push_back(lw(k));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 0; e < 2 * DEPTH + 2; e++) begin
            @(negedge clk);
            chk("ld_we", 32'(ram_we),
                32'(e >= 2 && e <= 2 * DEPTH && e % 2 == 0));
            chk("ld_busy", 32'(busy), 32'(e < 2 * DEPTH));
            chk("ld_done", 32'(done), 32'(e == 2 * DEPTH));
            @(posedge clk);
            #1 start = (e == glitch);
        end
        start = 1'b0;
    endtask

    initial begin
        int j;
        int hj;
        logic g;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        host_req = 1'b1;
        host_ad = '0;
        host_data = '0;
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_ad", 32'(ram_ad), 0);
        chk("rst_data", 32'(ram_data), 0);
        chk("rst_romad", 32'(rom_ad), 0);
        chk("rst_gnt", 32'(host_gnt), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        host_req = 1'b0;

        // Single host write while idle
        host_req = 1'b1;
        host_ad = 10'h3FF;
        host_data = 18'h2AAAA;
        expq.push_back({10'h3FF, 18'h2AAAA});
        @(negedge clk);
        chk("idle_gnt", 32'(host_gnt), 1);
        @(posedge clk);
        #1 host_req = 1'b0;
        @(negedge clk);
        chk("idle_we", 32'(ram_we), 1);
        @(posedge clk);
        #1;

        // Uncontended load
        run_load(-1);

        // Reset during word 3
        for (int k = 0; k < 3; k++) expq.push_back(lw(k));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        host_req = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_we", 32'(ram_we), 0);
        chk("mrst_ad", 32'(ram_ad), 0);
        chk("mrst_data", 32'(ram_data), 0);
        chk("mrst_romad", 32'(rom_ad), 0);
        chk("mrst_gnt", 32'(host_gnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        host_req = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_we", 32'(ram_we), 0);
        end
        @(posedge clk);
        #1;

        // Continuous host stream: per word 1 FETCH + 4 WRITE host grants
        hj = 0;
        for (int n = 1; n <= 6 * DEPTH; n++) begin
            if (n % 6 == 0) expq.push_back(lw(n / 6 - 1));
            else begin
                expq.push_back(hw(hj));
                hj++;
            end
        end
        j = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        host_req = 1'b1;
        {host_ad, host_data} = hw(j);
        for (int e = 0; e < 6 * DEPTH; e++) begin
            @(negedge clk);
            g = host_gnt;
            chk("str_gnt", 32'(g), 32'(e % 6 != 5));
            @(posedge clk);
            #1;
            if (g) begin
                j++;
                {host_ad, host_data} = hw(j);
            end
        end
        host_req = 1'b0;
        chk("str_count", 32'(j), 32'(5 * DEPTH));
        @(negedge clk);
        chk("str_done", 32'(done), 1);
        chk("str_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

        // Abort in WRITE of word 5
        for (int k = 0; k < 5; k++) expq.push_back(lw(k));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_we", 32'(ram_we), 0);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            chk("abort_done", 32'(done), 0);
        end
        @(posedge clk);
        #1;
        run_load(-1);

        // start+abort together in idle, then start pulsed mid-load
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("sa_busy", 32'(busy), 0);
        chk("sa_we", 32'(ram_we), 0);
        @(posedge clk);
        #1;
        run_load(5);
        repeat (3) @(negedge clk) chk("tail_done", 32'(done), 0);

        chk("queue_empty", 32'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
